// File: rtl/bpu_if.sv
// Fetch/execute-facing bundle for the branch predict unit: lookup port, resolve port,
// registered results and statistics.
interface bpu_if #(
    parameter int PC_W  = 16,
    parameter int CNT_W = 16
);
    logic             lookup_valid;
    logic [PC_W-1:0]  lookup_pc;
    logic             pred_valid;
    logic             pred_taken;
    logic             resolve_valid;
    logic [4:0]       resolve_opcode;
    logic [1:0]       resolve_flags;
    logic [PC_W-1:0]  resolve_pc;
    logic             resolve_pred;
    logic             taken_out;
    logic             mispredict;
    logic             resolve_done;
    logic [CNT_W-1:0] branch_cnt;
    logic [CNT_W-1:0] mispred_cnt;

    modport master (
        output lookup_valid, lookup_pc,
        output resolve_valid, resolve_opcode, resolve_flags, resolve_pc, resolve_pred,
        input  pred_valid, pred_taken, taken_out, mispredict, resolve_done,
        input  branch_cnt, mispred_cnt
    );

    modport slave (
        input  lookup_valid, lookup_pc,
        input  resolve_valid, resolve_opcode, resolve_flags, resolve_pc, resolve_pred,
        output pred_valid, pred_taken, taken_out, mispredict, resolve_done,
        output branch_cnt, mispred_cnt
    );
endinterface

// File: rtl/branch_predict_unit.sv
// Branch resolve from ALU flags plus a direct-mapped table of 2-bit saturating
// counters for fetch-time prediction, with saturating branch/mispredict statistics.
module branch_predict_unit #(
    parameter int         PC_W     = 16,
    parameter int         IDX_W    = 4,
    parameter int         CNT_W    = 16,
    parameter logic [1:0] CTR_INIT = 2'b01
) (
    input logic  clk,
    input logic  rst,
    bpu_if.slave bus
);
    localparam int         DEPTH  = 2 ** IDX_W;
    localparam logic [4:0] OP_BEQ = 5'b10011;
    localparam logic [4:0] OP_BLT = 5'b10100;
    localparam logic [4:0] OP_BGT = 5'b10101;
    localparam logic [4:0] OP_BNE = 5'b10110;

    logic [1:0]       ctr_q [DEPTH];
    logic [1:0]       ctr_d [DEPTH];
    logic             pred_valid_q, pred_valid_d;
    logic             pred_taken_q, pred_taken_d;
    logic             taken_out_q, taken_out_d;
    logic             mispredict_q, mispredict_d;
    logic             resolve_done_q, resolve_done_d;
    logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
    logic [CNT_W-1:0] mispred_cnt_q, mispred_cnt_d;

    logic             is_branch;
    logic             actual;
    logic             miss;
    logic [IDX_W-1:0] upd_idx;
    logic [IDX_W-1:0] lk_idx;
    logic [1:0]       cur_ctr;

    always_comb begin
        is_branch = 1'b1;
        actual    = 1'b0;
        unique case (bus.resolve_opcode)
            OP_BEQ:  actual = bus.resolve_flags[1];
            OP_BNE:  actual = ~bus.resolve_flags[1];
            OP_BLT:  actual = bus.resolve_flags[0];
            OP_BGT:  actual = ~bus.resolve_flags[0];
            default: is_branch = 1'b0;
        endcase
        miss    = actual ^ bus.resolve_pred;
        upd_idx = bus.resolve_pc[IDX_W-1:0];
        lk_idx  = bus.lookup_pc[IDX_W-1:0];
        cur_ctr = ctr_q[upd_idx];

        ctr_d = ctr_q;
        if (bus.resolve_valid && is_branch) begin
            if (actual)
                ctr_d[upd_idx] = (cur_ctr == 2'b11) ? cur_ctr : cur_ctr + 2'd1;
            else
                ctr_d[upd_idx] = (cur_ctr == 2'b00) ? cur_ctr : cur_ctr - 2'd1;
        end

        // Reading the post-update table gives the write-first bypass for free.
        pred_valid_d = bus.lookup_valid;
        pred_taken_d = bus.lookup_valid ? ctr_d[lk_idx][1] : pred_taken_q;

        taken_out_d    = bus.resolve_valid ? actual : taken_out_q;
        resolve_done_d = bus.resolve_valid;
        mispredict_d   = bus.resolve_valid && miss;

        branch_cnt_d  = branch_cnt_q;
        mispred_cnt_d = mispred_cnt_q;
        if (bus.resolve_valid && is_branch && (branch_cnt_q != '1))
            branch_cnt_d = branch_cnt_q + CNT_W'(1);
        if (bus.resolve_valid && miss && (mispred_cnt_q != '1))
            mispred_cnt_d = mispred_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ctr_q          <= '{default: CTR_INIT};
            pred_valid_q   <= 1'b0;
            pred_taken_q   <= 1'b0;
            taken_out_q    <= 1'b0;
            mispredict_q   <= 1'b0;
            resolve_done_q <= 1'b0;
            branch_cnt_q   <= '0;
            mispred_cnt_q  <= '0;
        end else begin
            ctr_q          <= ctr_d;
            pred_valid_q   <= pred_valid_d;
            pred_taken_q   <= pred_taken_d;
            taken_out_q    <= taken_out_d;
            mispredict_q   <= mispredict_d;
            resolve_done_q <= resolve_done_d;
            branch_cnt_q   <= branch_cnt_d;
            mispred_cnt_q  <= mispred_cnt_d;
        end
    end

    assign bus.pred_valid   = pred_valid_q;
    assign bus.pred_taken   = pred_taken_q;
    assign bus.taken_out    = taken_out_q;
    assign bus.mispredict   = mispredict_q;
    assign bus.resolve_done = resolve_done_q;
    assign bus.branch_cnt   = branch_cnt_q;
    assign bus.mispred_cnt  = mispred_cnt_q;
endmodule

// File: tb/tb_branch_predict_unit.sv
// Scoreboard bench: directed plan items then random traffic, checked against a
// counter-array reference model on a full-width and a 4-bit-statistics instance.
module tb_branch_predict_unit;
    localparam int PC_W = 16;
    localparam int IDX_W = 4;
    localparam int DEPTH = 16;

    typedef struct {
        logic pv, pt, rd, to, mp;
        int   bc, mc, bcs, mcs;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic lv = 1'b0, rv = 1'b0, rp = 1'b0;
    logic [PC_W-1:0] lpc = '0, rpc = '0;
    logic [4:0] op = '0;
    logic [1:0] fl = '0;

    int n_chk = 0;
    int n_fail = 0;
    exp_t exp_q[$];

    // reference model state
    int   m_ctr[DEPTH];
    logic m_pt, m_to;
    int   m_bc, m_mc, m_bcs, m_mcs;

    always #5 clk = ~clk;

    bpu_if #(.PC_W(PC_W), .CNT_W(16)) bi ();
    bpu_if #(.PC_W(PC_W), .CNT_W(4))  bs ();

    assign bi.lookup_valid = lv;   assign bs.lookup_valid = lv;
    assign bi.lookup_pc = lpc;     assign bs.lookup_pc = lpc;
    assign bi.resolve_valid = rv;  assign bs.resolve_valid = rv;
    assign bi.resolve_opcode = op; assign bs.resolve_opcode = op;
    assign bi.resolve_flags = fl;  assign bs.resolve_flags = fl;
    assign bi.resolve_pc = rpc;    assign bs.resolve_pc = rpc;
    assign bi.resolve_pred = rp;   assign bs.resolve_pred = rp;

    branch_predict_unit #(.PC_W(PC_W), .IDX_W(IDX_W), .CNT_W(16), .CTR_INIT(2'b01))
        dut (.clk(clk), .rst(rst), .bus(bi));
    branch_predict_unit #(.PC_W(PC_W), .IDX_W(IDX_W), .CNT_W(4), .CTR_INIT(2'b01))
        dut_small (.clk(clk), .rst(rst), .bus(bs));

    task automatic chk(input string nm, input int act, input int expv);
        n_chk++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, expv, $time);
        end
    endtask

    function automatic logic direction(input logic [4:0] o, input logic [1:0] f);
        case (o)
            5'b10011: return f[1];
            5'b10110: return !f[1];
            5'b10100: return f[0];
            5'b10101: return !f[0];
            default:  return 1'b0;
        endcase
    endfunction

    function automatic bit is_br(input logic [4:0] o);
        return o inside {5'b10011, 5'b10100, 5'b10101, 5'b10110};
    endfunction

    // Drive one cycle of stimulus and push what the outputs must be after the next edge.
    task automatic step(input logic r, input logic l_v, input logic [PC_W-1:0] l_pc,
                        input logic r_v, input logic [4:0] o, input logic [1:0] f,
                        input logic [PC_W-1:0] r_pc, input logic r_p);
        exp_t e;
        logic act;
        int idx;
        @(negedge clk);
        rst = r; lv = l_v; lpc = l_pc; rv = r_v; op = o; fl = f; rpc = r_pc; rp = r_p;
        if (r) begin
            for (int i = 0; i < DEPTH; i++) m_ctr[i] = 1;
            m_pt = 0; m_to = 0; m_bc = 0; m_mc = 0; m_bcs = 0; m_mcs = 0;
            e.pv = 0; e.rd = 0; e.mp = 0;
        end else begin
            act = direction(o, f);
            e.rd = r_v;
            e.mp = r_v && (act != r_p);
            if (r_v) begin
                m_to = act;
                if (is_br(o)) begin
                    idx = int'(r_pc) % DEPTH;
                    m_ctr[idx] = act ? ((m_ctr[idx] + 1 > 3) ? 3 : m_ctr[idx] + 1)
                                     : ((m_ctr[idx] - 1 < 0) ? 0 : m_ctr[idx] - 1);
                    if (m_bc < 65535) m_bc++;
                    if (m_bcs < 15) m_bcs++;
                end
                if (e.mp) begin
                    if (m_mc < 65535) m_mc++;
                    if (m_mcs < 15) m_mcs++;
                end
            end
            e.pv = l_v;
            if (l_v) m_pt = (m_ctr[int'(l_pc) % DEPTH] >= 2);
        end
        e.pt = m_pt; e.to = m_to;
        e.bc = m_bc; e.mc = m_mc; e.bcs = m_bcs; e.mcs = m_mcs;
        exp_q.push_back(e);
    endtask

    task automatic lookup(input logic [PC_W-1:0] pc);
        step(0, 1, pc, 0, 5'd0, 2'b00, '0, 0);
    endtask

    task automatic resolve(input logic [4:0] o, input logic [1:0] f,
                           input logic [PC_W-1:0] pc, input logic p);
        step(0, 0, '0, 1, o, f, pc, p);
    endtask

    // Monitor: compare the DUT against each expected entry just after the capturing edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("pred_valid", int'(bi.pred_valid), int'(e.pv));
                chk("pred_taken", int'(bi.pred_taken), int'(e.pt));
                chk("resolve_done", int'(bi.resolve_done), int'(e.rd));
                chk("taken_out", int'(bi.taken_out), int'(e.to));
                chk("mispredict", int'(bi.mispredict), int'(e.mp));
                chk("branch_cnt", int'(bi.branch_cnt), e.bc);
                chk("mispred_cnt", int'(bi.mispred_cnt), e.mc);
                chk("branch_cnt_w4", int'(bs.branch_cnt), e.bcs);
                chk("mispred_cnt_w4", int'(bs.mispred_cnt), e.mcs);
                chk("pred_taken_w4", int'(bs.pred_taken), int'(e.pt));
            end
        end
    end

    initial begin
        logic [4:0] ops [4];
        logic [1:0] sweep_fl [12];
        logic [4:0] sweep_op [12];
        int wait_cyc;
        ops[0] = 5'b10011; ops[1] = 5'b10100; ops[2] = 5'b10101; ops[3] = 5'b10110;

        step(1, 0, '0, 0, 5'd0, 2'b00, '0, 0);
        step(1, 0, '0, 0, 5'd0, 2'b00, '0, 0);
        lookup(16'h0005);
        resolve(5'b10011, 2'b10, 16'h0005, 0);
        resolve(5'b10011, 2'b10, 16'h0005, 0);
        lookup(16'h0015);

        sweep_fl = '{2'b01, 2'b00, 2'b11, 2'b10, 2'b01, 2'b11, 2'b10, 2'b00,
                     2'b00, 2'b10, 2'b01, 2'b11};
        for (int i = 0; i < 12; i++)
            sweep_op[i] = (i < 4) ? 5'b10110 : (i < 8) ? 5'b10100 : 5'b10101;
        for (int i = 0; i < 12; i++) resolve(sweep_op[i], sweep_fl[i], 16'h0001, 1);

        for (int i = 0; i < 8; i++) resolve(5'b10101, 2'b01, 16'h0003, 0);
        lookup(16'h0003);

        for (int i = 0; i < 20; i++)
            resolve(5'b10011, 2'($urandom_range(0, 3)), 16'h0009, 1'($urandom_range(0, 1)));

        step(0, 1, 16'h0007, 1, 5'b10100, 2'b01, 16'h0007, 0);
        resolve(5'b00001, 2'b11, 16'h0007, 1);
        lookup(16'h0007);

        step(1, 1, 16'h0002, 1, 5'b10011, 2'b10, 16'h0002, 0);
        for (int i = 0; i < DEPTH; i++) lookup(PC_W'(i));
        // A taken resolve on every index moves 01->10, so each next lookup must predict taken.
        for (int i = 0; i < DEPTH; i++) begin
            resolve(5'b10011, 2'b10, PC_W'(i), 1);
            lookup(PC_W'(i + 32));
        end

        for (int i = 0; i < 400; i++) begin
            logic [PC_W-1:0] a, b;
            a = PC_W'($urandom);
            b = ($urandom_range(0, 3) == 0) ? a : PC_W'($urandom);
            step(($urandom_range(0, 63) == 0), 1'($urandom_range(0, 1)), b,
                 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 4) == 0) ? 5'($urandom) : ops[$urandom_range(0, 3)],
                 2'($urandom), a, 1'($urandom_range(0, 1)));
        end
        step(0, 0, '0, 0, 5'd0, 2'b00, '0, 0);

        wait_cyc = 0;
        while (exp_q.size() != 0 && wait_cyc < 10) begin
            @(negedge clk);
            wait_cyc++;
        end
        @(negedge clk);
        n_chk++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries left, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
